neuron_tick_scheduler: RTL and testbench

Sequences one shared threshold_reset_unit across NUM_NEURONS neurons whose membrane potentials live in a single-port synchronous RAM. On each global tick it sweeps neurons 0..NUM_NEURONS-1 in order. For each neuron it reads the potential, presents it to the threshold/reset unit, writes back the unit's reset potential, and emits a spike event on a valid/ready port when the neuron fires. It sits between the core's tick source, the neuron potential memory and the spike router.

---
 rtl/neuron_tick_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_neuron_tick_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_tick_scheduler.sv
// Sweeps all neurons once per tick through one shared threshold/reset unit,
// writing back post-reset potentials and emitting spike events for firing neurons.
module neuron_tick_scheduler #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned V_W         = 8,
    parameter int unsigned TRU_LATENCY = 1,
    parameter int unsigned CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        cfg_pos_neg_thresholds,
    input  logic              cfg_mask,
    input  logic [V_W-1:0]    cfg_v_reset,
    output logic              busy,
    output logic              tick_done,
    output logic              tick_overrun,
    output logic [CNT_W-1:0]  spike_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [V_W-1:0]    mem_rd_data,
    output logic              mem_wr_en,
    output logic [V_W-1:0]    mem_wr_data,
    output logic [V_W-1:0]    tru_membrane_potential,
    output logic [1:0]        tru_pos_neg_thresholds,
    output logic              tru_mask,
    output logic [V_W-1:0]    tru_v_reset,
    input  logic              tru_threshold_output,
    input  logic [V_W-1:0]    tru_reset_membrane_potential,
    output logic              spike_valid,
    output logic [ADDR_W-1:0] spike_addr,
    input  logic              spike_ready
);

    localparam int unsigned LAT_W = (TRU_LATENCY > 1) ? $clog2(TRU_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_EVAL, S_WRITE, S_SPIKE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [1:0]         cfg_mode_q, cfg_mode_d;
    logic               cfg_mask_q, cfg_mask_d;
    logic [V_W-1:0]     cfg_vr_q, cfg_vr_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   spike_count_q, spike_count_d;
    logic               busy_q, busy_d;
    logic               tick_done_q, tick_done_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic               mem_wr_en_q, mem_wr_en_d;
    logic [V_W-1:0]     tru_v_q, tru_v_d;
    logic [1:0]         tru_mode_q, tru_mode_d;
    logic               tru_mask_q, tru_mask_d;
    logic [V_W-1:0]     tru_vr_q, tru_vr_d;
    logic               spike_valid_q, spike_valid_d;
    logic [ADDR_W-1:0]  spike_addr_q, spike_addr_d;
    logic               adv;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lat_d         = lat_q;
        run_cnt_d     = run_cnt_q;
        cfg_mode_d    = cfg_mode_q;
        cfg_mask_d    = cfg_mask_q;
        cfg_vr_d      = cfg_vr_q;
        overrun_d     = overrun_q;
        spike_count_d = spike_count_q;
        tru_v_d       = tru_v_q;
        tru_mode_d    = tru_mode_q;
        tru_mask_d    = tru_mask_q;
        tru_vr_d      = tru_vr_q;
        adv           = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (tick) begin
                    cfg_mode_d = cfg_pos_neg_thresholds;
                    cfg_mask_d = cfg_mask;
                    cfg_vr_d   = cfg_v_reset;
                    idx_d      = '0;
                    run_cnt_d  = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                tru_v_d    = mem_rd_data;
                tru_mode_d = cfg_mode_q;
                tru_mask_d = cfg_mask_q;
                tru_vr_d   = cfg_vr_q;
                lat_d      = LAT_W'(TRU_LATENCY - 1);
                state_d    = S_EVAL;
            end
            S_EVAL: begin
                if (lat_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_WRITE: begin
                if (tru_threshold_output) begin
                    state_d   = S_SPIKE;
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end else begin
                    adv = 1'b1;
                end
            end
            S_SPIKE: adv = spike_ready;
            default: state_d = S_IDLE;
        endcase

        // Step to the next neuron or finish the sweep
        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_READ;
            end
        end

        if (tick && busy_q) begin
            overrun_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            spike_count_d = run_cnt_d;
        end

        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
        tick_done_d   = (state_d == S_DONE);
        mem_rd_en_d   = (state_d == S_READ);
        mem_wr_en_d   = (state_d == S_WRITE);
        mem_addr_d    = (mem_rd_en_d || mem_wr_en_d) ? idx_d : '0;
        spike_valid_d = (state_d == S_SPIKE);
        spike_addr_d  = spike_valid_d ? idx_d : '0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            lat_q         <= '0;
            run_cnt_q     <= '0;
            cfg_mode_q    <= '0;
            cfg_mask_q    <= 1'b0;
            cfg_vr_q      <= '0;
            overrun_q     <= 1'b0;
            spike_count_q <= '0;
            busy_q        <= 1'b0;
            tick_done_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            tru_v_q       <= '0;
            tru_mode_q    <= '0;
            tru_mask_q    <= 1'b0;
            tru_vr_q      <= '0;
            spike_valid_q <= 1'b0;
            spike_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            lat_q         <= lat_d;
            run_cnt_q     <= run_cnt_d;
            cfg_mode_q    <= cfg_mode_d;
            cfg_mask_q    <= cfg_mask_d;
            cfg_vr_q      <= cfg_vr_d;
            overrun_q     <= overrun_d;
            spike_count_q <= spike_count_d;
            busy_q        <= busy_d;
            tick_done_q   <= tick_done_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            tru_v_q       <= tru_v_d;
            tru_mode_q    <= tru_mode_d;
            tru_mask_q    <= tru_mask_d;
            tru_vr_q      <= tru_vr_d;
            spike_valid_q <= spike_valid_d;
            spike_addr_q  <= spike_addr_d;
        end
    end

    assign busy                   = busy_q;
    assign tick_done              = tick_done_q;
    assign tick_overrun           = overrun_q;
    assign spike_count            = spike_count_q;
    assign mem_addr               = mem_addr_q;
    assign mem_rd_en              = mem_rd_en_q;
    assign mem_wr_en              = mem_wr_en_q;
    // Unit result is only valid during the write cycle, so it passes straight through
    assign mem_wr_data            = mem_wr_en_q ? tru_reset_membrane_potential : '0;
    assign tru_membrane_potential = tru_v_q;
    assign tru_pos_neg_thresholds = tru_mode_q;
    assign tru_mask               = tru_mask_q;
    assign tru_v_reset            = tru_vr_q;
    assign spike_valid            = spike_valid_q;
    assign spike_addr             = spike_addr_q;

endmodule

// File: tb/tb_neuron_tick_scheduler.sv
// Scoreboard bench: reference sweep model predicts writes, spikes and counts per tick.
`timescale 1ns/1ps
module tb_neuron_tick_scheduler;
    localparam int unsigned N = 4, AW = 2, VW = 8, LAT = 1, CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic [1:0] cfg_mode = 2'b01;
    logic cfg_mask = 1'b0;
    logic [VW-1:0] cfg_vr = '0;
    logic busy, tick_done, tick_overrun, mem_rd_en, mem_wr_en, tru_mask, spike_valid;
    logic [CW-1:0] spike_count;
    logic [AW-1:0] mem_addr, spike_addr;
    logic [VW-1:0] mem_rd_data, mem_wr_data, tru_mp, tru_vr, tru_rv;
    logic [1:0] tru_mode;
    logic tru_fire;
    logic spike_ready;

    neuron_tick_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW), .V_W(VW),
                            .TRU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cfg_pos_neg_thresholds(cfg_mode), .cfg_mask(cfg_mask), .cfg_v_reset(cfg_vr),
        .busy(busy), .tick_done(tick_done), .tick_overrun(tick_overrun),
        .spike_count(spike_count), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .tru_membrane_potential(tru_mp), .tru_pos_neg_thresholds(tru_mode),
        .tru_mask(tru_mask), .tru_v_reset(tru_vr),
        .tru_threshold_output(tru_fire), .tru_reset_membrane_potential(tru_rv),
        .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_ready(spike_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM with a backdoor load port
    logic [VW-1:0] ram [N];
    logic bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [VW-1:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    // Threshold unit: one-cycle latency, fires above 0x80 in mode 01
    always @(posedge clk) begin
        tru_fire <= (tru_mode == 2'b01) && (tru_mp > 8'h80);
        tru_rv   <= ((tru_mode == 2'b01) && (tru_mp > 8'h80)) ? tru_vr : tru_mp;
    end

    // spike_ready driver: 0 = always ready, 1 = stalled, 2 = random
    int ready_mode = 0;
    initial begin
        spike_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       spike_ready = 1'b1;
                1:       spike_ready = 1'b0;
                default: spike_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    int checks = 0;
    int errors = 0;
    int ref_ram [N];
    int exp_wr_addr [$];
    int exp_wr_data [$];
    int exp_sp [$];
    int exp_cnt [$];
    int t0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=none (t=%0t)", name, act, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("strobe_excl", int'(mem_rd_en & mem_wr_en), 0);
            if (!mem_rd_en && !mem_wr_en) chk("addr_idle", int'(mem_addr), 0);
            if (mem_wr_en) begin
                if (exp_wr_addr.size() == 0) fail_now("unexpected_write", int'(mem_addr));
                else begin
                    chk("wr_addr", int'(mem_addr), exp_wr_addr.pop_front());
                    chk("wr_data", int'(mem_wr_data), exp_wr_data.pop_front());
                end
            end
            if (spike_valid && spike_ready) begin
                if (exp_sp.size() == 0) fail_now("unexpected_spike", int'(spike_addr));
                else chk("spike_addr", int'(spike_addr), exp_sp.pop_front());
            end
            if (tick_done) begin
                if (exp_cnt.size() == 0) fail_now("unexpected_done", int'(spike_count));
                else chk("spike_count", int'(spike_count), exp_cnt.pop_front());
            end
        end
    end

    // Reference: one full sweep with the latched config
    task automatic model_sweep(input logic [1:0] mode, input logic [7:0] vr);
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            int v = ref_ram[i];
            bit fire = (mode == 2'b01) && (v > 'h80);
            int nv = fire ? int'(vr) : v;
            exp_wr_addr.push_back(i);
            exp_wr_data.push_back(nv);
            if (fire) begin
                exp_sp.push_back(i);
                cnt++;
            end
            ref_ram[i] = nv;
        end
        exp_cnt.push_back(cnt);
    endtask

    task automatic load_ram(input logic [31:0] w);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            bd_we = 1'b1;
            bd_addr = AW'(i);
            bd_data = w[8*i +: 8];
            ref_ram[i] = int'(w[8*i +: 8]);
        end
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic start_sweep(input logic [1:0] mode, input logic [7:0] vr, input logic mask);
        cfg_mode = mode;
        cfg_vr = vr;
        cfg_mask = mask;
        tick = 1'b1;
        t0 = cyc;
        model_sweep(mode, vr);
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic wait_done(output int dur, output int busy_cnt);
        bit found = 0;
        dur = -1;
        busy_cnt = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (tick_done) begin
                dur = cyc - t0;
                found = 1;
            end
        end
        if (!found) fail_now("done_timeout", dur);
        @(posedge clk); #1;
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_ram%0d", tag, i), int'(ram[i]), ref_ram[i]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_tick_done"}, int'(tick_done), 0);
        chk({tag, "_overrun"}, int'(tick_overrun), 0);
        chk({tag, "_spike_count"}, int'(spike_count), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_wr_en"}, int'(mem_wr_en), 0);
        chk({tag, "_wr_data"}, int'(mem_wr_data), 0);
        chk({tag, "_tru_mp"}, int'(tru_mp), 0);
        chk({tag, "_tru_mode"}, int'(tru_mode), 0);
        chk({tag, "_tru_mask"}, int'(tru_mask), 0);
        chk({tag, "_tru_vr"}, int'(tru_vr), 0);
        chk({tag, "_spike_valid"}, int'(spike_valid), 0);
        chk({tag, "_spike_addr"}, int'(spike_addr), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dur, bc;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // No firing neurons
        load_ram(32'h3020_1070);
        start_sweep(2'b01, 8'h20, 1'b0);
        wait_done(dur, bc);
        chk("nospike_done_cycle", dur, 17);
        chk("nospike_busy_cycles", bc, 16);
        chk("nospike_overrun", int'(tick_overrun), 0);
        check_ram("nospike");

        // Two firing neurons, always ready
        load_ram(32'hA010_9070);
        start_sweep(2'b01, 8'h20, 1'b0);
        wait_done(dur, bc);
        chk("spike_done_cycle", dur, 19);
        chk("spike_busy_cycles", bc, 18);
        check_ram("spike");

        // Downstream stall of 5 cycles at the first spike
        load_ram(32'hA010_9070);
        ready_mode = 1;
        start_sweep(2'b01, 8'h20, 1'b0);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (spike_valid) seen = 1;
        end
        if (!seen) fail_now("stall_spike_timeout", 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", int'(spike_valid), 1);
            chk("stall_addr", int'(spike_addr), 1);
            chk("stall_no_read", int'(mem_rd_en), 0);
            @(posedge clk);
        end
        #1;
        ready_mode = 0;
        wait_done(dur, bc);
        chk("stall_done_cycle", dur, 24);
        check_ram("stall");

        // Tick and config change mid-sweep
        load_ram(32'hA010_9070);
        start_sweep(2'b01, 8'h20, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        tick = 1'b1;
        cfg_vr = 8'h55;
        @(posedge clk); #1;
        tick = 1'b0;
        wait_done(dur, bc);
        chk("overrun_done_cycle", dur, 19);
        check_ram("overrun");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("overrun_sticky", int'(tick_overrun), 1);
        @(posedge clk); #1;

        // Reset during evaluation of neuron 2 abandons the sweep
        load_ram(32'h3020_1070);
        start_sweep(2'b01, 8'h20, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_sp.delete();
        exp_cnt.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        repeat (4) @(posedge clk);
        #1;
        start_sweep(2'b01, 8'h20, 1'b0);
        wait_done(dur, bc);
        chk("restart_done_cycle", dur, 17);
        check_ram("restart");

        // Randomized sweeps with random backpressure
        ready_mode = 2;
        for (int s = 0; s < 12; s++) begin
            logic [1:0] mode;
            mode = ($urandom_range(0, 3) == 3) ? 2'b00 : 2'b01;
            load_ram($urandom);
            start_sweep(mode, 8'($urandom), 1'($urandom_range(0, 1)));
            wait_done(dur, bc);
            chk("rand_min_length", int'(dur >= 17), 1);
            check_ram($sformatf("rand%0d", s));
        end
        ready_mode = 0;
        repeat (5) @(posedge clk);
        chk("leftover_writes", exp_wr_addr.size(), 0);
        chk("leftover_spikes", exp_sp.size(), 0);
        chk("leftover_done", exp_cnt.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
